data_memory_lsu: RTL and testbench

// - Next-generation data memory for the MIPS datapath: byte-addressed, byte/half/word(/dword) access with

---
 rtl/dmem_pkg.sv | 23 ++
 rtl/data_memory_lsu_if.sv | 26 ++
 rtl/dmem_lane_align.sv | 70 +++++++
 rtl/data_memory_lsu.sv | 118 +++++++++++
 tb/tb_data_memory_lsu.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data memory load/store unit.
package dmem_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10,
    SZ_D = 2'b11
  } size_e;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_IDLE = 1'b1
  } state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/data_memory_lsu_if.sv
// Request/response bus between the datapath and the data memory.
interface data_memory_lsu_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [1:0]            req_size;
  logic                  req_uns;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;

  modport master (
    output req_valid, req_we, req_size, req_uns, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_uns, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_lane_align.sv
// Byte-lane steering: store byte-enables and shifted data, load extraction
// with sign/zero extension, and the misalignment / illegal-size flag.
module dmem_lane_align
  import dmem_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  localparam int NB = DATA_WIDTH / 8,
  localparam int OW = clog2(NB)
) (
  input  size_e                 size_i,
  input  logic                  uns_i,
  input  logic [OW-1:0]         off_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [DATA_WIDTH-1:0] rword_i,
  output logic [NB-1:0]         be_o,
  output logic [DATA_WIDTH-1:0] wdata_sh_o,
  output logic [DATA_WIDTH-1:0] rdata_ext_o,
  output logic                  misalign_o
);

  logic [DATA_WIDTH-1:0] rshift;
  logic [DATA_WIDTH-1:0] mask;
  logic                  sign;
  int                    nbytes;

  assign wdata_sh_o = wdata_i << {off_i, 3'b000};
  assign rshift     = rword_i >> {off_i, 3'b000};

  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    nbytes     = 1;
    mask       = DATA_WIDTH'(8'hFF);
    sign       = 1'b0;
    misalign_o = 1'b0;
    unique case (size_i)
      SZ_B: begin
        nbytes = 1;
        mask   = DATA_WIDTH'(8'hFF);
        sign   = rshift[7];
      end
      SZ_H: begin
        nbytes     = 2;
        mask       = DATA_WIDTH'(16'hFFFF);
        sign       = rshift[15];
        misalign_o = off_i[0];
      end
      SZ_W: begin
        nbytes     = 4;
        mask       = DATA_WIDTH'(32'hFFFF_FFFF);
        sign       = rshift[31];
        misalign_o = (off_i[1:0] != 2'b00);
      end
      SZ_D: begin
        nbytes     = 8;
        mask       = '1;
        sign       = 1'b0;
        // A dword only exists on a 64-bit array.
        misalign_o = (DATA_WIDTH == 32) || (off_i != '0);
      end
      default: ;
    endcase

    for (int i = 0; i < NB; i++) begin
      be_o[i] = (i >= int'(off_i)) && (i < int'(off_i) + nbytes);
    end

    rdata_ext_o = (rshift & mask) | ((sign && !uns_i) ? ~mask : '0);
  end

endmodule

// File: rtl/data_memory_lsu.sv
// Byte-addressed data memory with counter-driven clearing, valid/ready
// requests and a one-cycle registered response.
module data_memory_lsu
  import dmem_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 1024,
  parameter int ADDR_WIDTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  output logic              init_busy,
  data_memory_lsu_if.slave  bus
);

  localparam int NB = DATA_WIDTH / 8;
  localparam int OW = clog2(NB);
  localparam int CW = (clog2(DEPTH) > 0) ? clog2(DEPTH) : 1;

  state_e                state_q;
  logic [CW-1:0]         init_cnt_q;
  logic                  rsp_valid_q;
  logic                  rsp_err_q;
  logic [DATA_WIDTH-1:0] rsp_rdata_q;
  logic [DATA_WIDTH-1:0] rsp_rdata_d;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_WIDTH-1:0] widx;
  logic [CW-1:0]         mem_idx;
  logic                  in_range;
  logic                  misalign;
  logic                  err;
  logic                  accept;
  logic [DATA_WIDTH-1:0] rd_word;
  logic [DATA_WIDTH-1:0] ld_data;
  logic [DATA_WIDTH-1:0] wdata_sh;
  logic [NB-1:0]         be;
  logic                  wr_init;
  logic                  wr_store;

  assign widx      = bus.req_addr >> OW;
  assign mem_idx   = widx[CW-1:0];
  assign in_range  = widx < ADDR_WIDTH'(DEPTH);
  assign rd_word   = in_range ? mem[mem_idx] : '0;

  dmem_lane_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
    .size_i      (size_e'(bus.req_size)),
    .uns_i       (bus.req_uns),
    .off_i       (bus.req_addr[OW-1:0]),
    .wdata_i     (bus.req_wdata),
    .rword_i     (rd_word),
    .be_o        (be),
    .wdata_sh_o  (wdata_sh),
    .rdata_ext_o (ld_data),
    .misalign_o  (misalign)
  );

  assign err           = misalign || !in_range;
  assign bus.req_ready = (state_q == ST_IDLE) && !clear;
  assign accept        = rst && bus.req_valid && bus.req_ready;
  assign wr_init       = rst && (state_q == ST_INIT);
  assign wr_store      = accept && bus.req_we && !err;
  assign rsp_rdata_d   = (bus.req_we || err) ? '0 : ld_data;

  assign init_busy     = (state_q == ST_INIT);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = rsp_rdata_q;

  // NOTE: the array has no reset; it is cleared one word per cycle by the init sequence.
  always_ff @(posedge clk) begin
    if (wr_init) begin
      mem[init_cnt_q] <= '0;
    end else if (wr_store) begin
      for (int i = 0; i < NB; i++) begin
        if (be[i]) mem[mem_idx][i*8 +: 8] <= wdata_sh[i*8 +: 8];
      end
    end
  end

  // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_INIT;
      init_cnt_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      unique case (state_q)
        ST_INIT: begin
          if (init_cnt_q == CW'(DEPTH - 1)) begin
            state_q    <= ST_IDLE;
            init_cnt_q <= '0;
          end else begin
            init_cnt_q <= init_cnt_q + CW'(1);
          end
        end
        ST_IDLE: begin
          if (clear) begin
            state_q    <= ST_INIT;
            init_cnt_q <= '0;
          end else if (accept) begin
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= err;
            rsp_rdata_q <= rsp_rdata_d;
          end
        end
        default: state_q <= ST_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_data_memory_lsu.sv
// Scoreboard bench for data_memory_lsu: a 32-bit instance with non-power-of-two
// depth and a small 64-bit instance for dword traffic.
module tb_data_memory_lsu;

  localparam int DEPTH   = 80;
  localparam int DEPTH64 = 6;

  typedef struct {
    string       tag;
    logic [63:0] rdata;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic clear, clear64;
  logic init_busy, init_busy64;

  data_memory_lsu_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus   ();
  data_memory_lsu_if #(.DATA_WIDTH(64), .ADDR_WIDTH(32)) bus64 ();

  data_memory_lsu #(.DATA_WIDTH(32), .DEPTH(DEPTH), .ADDR_WIDTH(32)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .init_busy (init_busy),
    .bus       (bus)
  );

  data_memory_lsu #(.DATA_WIDTH(64), .DEPTH(DEPTH64), .ADDR_WIDTH(32)) u_dut64 (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear64),
    .init_busy (init_busy64),
    .bus       (bus64)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_pass   = 0;
  exp_t exp_q[$];
  exp_t exp64_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Response monitors: sample one time unit after the active edge.
  always begin
    @(posedge clk);
    #1;
    if (bus.rsp_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_rsp32", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check({e.tag, "_err"},   64'(bus.rsp_err),   64'(e.err));
        check({e.tag, "_rdata"}, 64'(bus.rsp_rdata), e.rdata);
      end
    end
  end

  always begin
    @(posedge clk);
    #1;
    if (bus64.rsp_valid === 1'b1) begin
      if (exp64_q.size() == 0) begin
        check("unexpected_rsp64", 1, 0);
      end else begin
        exp_t e;
        e = exp64_q.pop_front();
        check({e.tag, "_err"},   64'(bus64.rsp_err), 64'(e.err));
        check({e.tag, "_rdata"}, bus64.rsp_rdata,    e.rdata);
      end
    end
  end

  // Drive one request for one cycle (called just after a negedge).
  task automatic issue(input string tag, input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rdata, input logic exp_err);
    exp_t e;
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_size  = size;
    bus.req_uns   = uns;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    e.tag = tag; e.rdata = 64'(exp_rdata); e.err = exp_err;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic issue64(input string tag, input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [63:0] wdata,
                         input logic [63:0] exp_rdata, input logic exp_err);
    exp_t e;
    bus64.req_valid = 1'b1;
    bus64.req_we    = we;
    bus64.req_size  = size;
    bus64.req_uns   = uns;
    bus64.req_addr  = addr;
    bus64.req_wdata = wdata;
    e.tag = tag; e.rdata = exp_rdata; e.err = exp_err;
    exp64_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic idle();
    bus.req_valid   = 1'b0;
    bus64.req_valid = 1'b0;
    @(negedge clk);
  endtask

  // Count busy cycles of both instances from the current negedge, bounded.
  task automatic count_init(input string tag, input int exp32, input int exp64);
    int n32, n64, guard;
    n32 = 0; n64 = 0; guard = 0;
    while ((init_busy || init_busy64) && guard < 4 * DEPTH) begin
      if (init_busy)   n32++;
      if (init_busy64) n64++;
      guard++;
      @(negedge clk);
    end
    check({tag, "_cycles32"}, 64'(n32), 64'(exp32));
    check({tag, "_cycles64"}, 64'(n64), 64'(exp64));
    check({tag, "_ready"},    64'(bus.req_ready), 64'(1));
  endtask

  initial begin
    rst = 1'b0; clear = 1'b0; clear64 = 1'b0;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'b00; bus.req_uns = 1'b0;
    bus.req_addr = '0; bus.req_wdata = '0;
    bus64.req_valid = 1'b0; bus64.req_we = 1'b0; bus64.req_size = 2'b00; bus64.req_uns = 1'b0;
    bus64.req_addr = '0; bus64.req_wdata = '0;

    // Reset for two cycles, then the init sequence must last exactly DEPTH cycles.
    repeat (2) @(negedge clk);
    check("rst_init_busy", 64'(init_busy),     64'(1));
    check("rst_req_ready", 64'(bus.req_ready), 64'(0));
    check("rst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
    check("rst_rsp_err",   64'(bus.rsp_err),   64'(0));
    check("rst_rsp_rdata", 64'(bus.rsp_rdata), 64'(0));
    rst = 1'b1;
    count_init("reset", DEPTH, DEPTH64);

    issue("ld0_w0",    0, 2'b10, 0, 32'h0,   '0, 32'h0, 0);
    issue("ld0_wlast", 0, 2'b10, 0, 32'h13C, '0, 32'h0, 0);

    // Byte store and extending loads.
    issue("sb_103",  1, 2'b00, 0, 32'h103, 32'h0000_00A5, 32'h0,         0);
    issue("lw_100",  0, 2'b10, 0, 32'h100, '0,            32'hA500_0000, 0);
    issue("lb_103",  0, 2'b00, 0, 32'h103, '0,            32'hFFFF_FFA5, 0);
    issue("lbu_103", 0, 2'b00, 1, 32'h103, '0,            32'h0000_00A5, 0);

    // Half-word merge on back-to-back cycles.
    issue("sw_20",  1, 2'b10, 0, 32'h20, 32'h1122_3344, 32'h0,         0);
    issue("sh_22",  1, 2'b01, 0, 32'h22, 32'h0000_BEEF, 32'h0,         0);
    issue("lw_20",  0, 2'b10, 0, 32'h20, '0,            32'hBEEF_3344, 0);
    issue("lh_22",  0, 2'b01, 0, 32'h22, '0,            32'hFFFF_BEEF, 0);
    issue("lhu_20", 0, 2'b01, 1, 32'h20, '0,            32'h0000_3344, 0);

    // Error cases leave the array untouched.
    issue("sw_40",     1, 2'b10, 0, 32'h40,        32'hCAFE_F00D, 32'h0, 0);
    issue("lh_41",     0, 2'b01, 0, 32'h41,        '0,            32'h0, 1);
    issue("sh_41",     1, 2'b01, 0, 32'h41,        32'h0000_1234, 32'h0, 1);
    issue("sw_42",     1, 2'b10, 0, 32'h42,        32'hDEAD_BEEF, 32'h0, 1);
    issue("lw_42",     0, 2'b10, 0, 32'h42,        '0,            32'h0, 1);
    issue("lw_oor",    0, 2'b10, 0, DEPTH * 4,     '0,            32'h0, 1);
    issue("sd_on32",   1, 2'b11, 0, 32'h40,        32'h5555_5555, 32'h0, 1);
    issue("lw_40_chk", 0, 2'b10, 0, 32'h40,        '0,            32'hCAFE_F00D, 0);
    issue("sw_last",   1, 2'b10, 0, (DEPTH-1) * 4, 32'h7777_8888, 32'h0, 0);
    issue("lw_last",   0, 2'b10, 0, (DEPTH-1) * 4, '0,            32'h7777_8888, 0);
    idle();

    // Clear wins over a simultaneous request.
    clear = 1'b1;
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_size = 2'b10; bus.req_addr = 32'h20;
    #1;
    check("clear_ready_low", 64'(bus.req_ready), 64'(0));
    @(negedge clk);
    clear = 1'b0;
    bus.req_valid = 1'b0;
    check("clear_busy", 64'(init_busy), 64'(1));
    count_init("clear", DEPTH, 0);
    issue("clr_lw_100",  0, 2'b10, 0, 32'h100,       '0, 32'h0, 0);
    issue("clr_lw_20",   0, 2'b10, 0, 32'h20,        '0, 32'h0, 0);
    issue("clr_lw_40",   0, 2'b10, 0, 32'h40,        '0, 32'h0, 0);
    issue("clr_lw_last", 0, 2'b10, 0, (DEPTH-1) * 4, '0, 32'h0, 0);
    idle();

    // Reset five cycles into an init sequence restarts it from word 0.
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    count_init("midreset", DEPTH, DEPTH64);

    // 64-bit instance: dword round trip plus narrower views of it.
    issue64("sd_8",     1, 2'b11, 0, 32'h8,  64'h0123_4567_89AB_CDEF, 64'h0,                   0);
    issue64("ld_8",     0, 2'b11, 0, 32'h8,  '0,                      64'h0123_4567_89AB_CDEF, 0);
    issue64("lw_c",     0, 2'b10, 0, 32'hC,  '0,                      64'h0000_0000_0123_4567, 0);
    issue64("lw_8",     0, 2'b10, 0, 32'h8,  '0,                      64'hFFFF_FFFF_89AB_CDEF, 0);
    issue64("lwu_8",    0, 2'b10, 1, 32'h8,  '0,                      64'h0000_0000_89AB_CDEF, 0);
    issue64("lb_f",     0, 2'b00, 0, 32'hF,  '0,                      64'h01,                  0);
    issue64("sd_4",     1, 2'b11, 0, 32'h4,  64'hFFFF_FFFF_FFFF_FFFF, 64'h0,                   1);
    issue64("ld_28",    0, 2'b11, 0, 32'h28, '0,                      64'h0,                   0);
    issue64("ld_oor",   0, 2'b11, 0, 32'h30, '0,                      64'h0,                   1);
    issue64("ld_8_chk", 0, 2'b11, 0, 32'h8,  '0,                      64'h0123_4567_89AB_CDEF, 0);
    idle();
    idle();

    check("pending32", 64'(exp_q.size()),   64'(0));
    check("pending64", 64'(exp64_q.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
